// File: rtl/fifo_read_ctrl_block.sv
// Read-side controller of the I2C FIFO: synchronizes the write pointer, drives the
// memory read address, tracks empty/level and presents words through a FWFT output register.
module fifo_read_ctrl_block #(
  parameter int data_size = 8,
  parameter int addr_size = 3
) (
  input  logic                 read_clock_i,
  input  logic                 read_reset_n_i,
  input  logic [addr_size:0]   write_ptr_gray_i,
  input  logic [data_size-1:0] mem_data_i,
  output logic [addr_size-1:0] read_addr_o,
  output logic [addr_size:0]   read_ptr_gray_o,
  output logic                 empty_o,
  output logic [data_size-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [addr_size:0]   level_o
);

  typedef logic [addr_size:0] ptr_t;

  ptr_t wq1;
  ptr_t wq2;
  ptr_t rbin;
  ptr_t rgray;
  ptr_t rbin_next;
  ptr_t rgray_next;
  ptr_t wbin;
  ptr_t level_next;
  logic mem_pop;

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[addr_size] = g[addr_size];
    for (int i = addr_size - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Plain two-flop synchronizer; the gray code guarantees at most one bit in flight.
  always_ff @(posedge read_clock_i or negedge read_reset_n_i) begin
    if (!read_reset_n_i) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= write_ptr_gray_i;
      wq2 <= wq1;
    end
  end

  // A word leaves memory whenever the output register is free or being drained.
  always_comb begin
    mem_pop    = ~empty_o & (~valid_o | ready_i);
    rbin_next  = rbin + ptr_t'(mem_pop);
    rgray_next = (rbin_next >> 1) ^ rbin_next;
    wbin       = gray2bin(wq2);
    level_next = wbin - rbin_next;
  end

  always_ff @(posedge read_clock_i or negedge read_reset_n_i) begin
    if (!read_reset_n_i) begin
      rbin    <= '0;
      rgray   <= '0;
      empty_o <= 1'b1;
      level_o <= '0;
    end else begin
      rbin    <= rbin_next;
      rgray   <= rgray_next;
      empty_o <= (rgray_next == wq2);
      level_o <= level_next;
    end
  end

  // Output register refills on a pop, otherwise clears once its word is taken.
  always_ff @(posedge read_clock_i or negedge read_reset_n_i) begin
    if (!read_reset_n_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (mem_pop) begin
      data_o  <= mem_data_i;
      valid_o <= 1'b1;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

  assign read_addr_o     = rbin[addr_size-1:0];
  assign read_ptr_gray_o = rgray;

endmodule

// File: tb/tb_fifo_read_ctrl_block.sv
// Directed bench for fifo_read_ctrl_block: cycle table for single word and backpressure,
// plus hand sequences for burst, pointer wrap and asynchronous reset.
module tb_fifo_read_ctrl_block;

  localparam int DS = 8;
  localparam int AS = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AS:0]   wptr_gray;
  logic [DS-1:0] mem_data;
  logic [AS-1:0] read_addr;
  logic [AS:0]   rgray;
  logic          empty;
  logic [DS-1:0] data;
  logic          valid;
  logic          ready;
  logic [AS:0]   level;

  logic [DS-1:0] mem [8];
  logic [DS-1:0] got_q [$];
  int            cyc_q [$];

  int n_compared = 0;
  int n_failed   = 0;

  typedef struct {
    logic [3:0] wptr;
    logic       rdy;
    logic       e_empty;
    logic       e_valid;
    logic [7:0] e_data;
    logic [3:0] e_rgray;
    logic [3:0] e_level;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  assign mem_data = mem[read_addr];

  fifo_read_ctrl_block #(.data_size(DS), .addr_size(AS)) dut (
    .read_clock_i     (clk),
    .read_reset_n_i   (rst_n),
    .write_ptr_gray_i (wptr_gray),
    .mem_data_i       (mem_data),
    .read_addr_o      (read_addr),
    .read_ptr_gray_o  (rgray),
    .empty_o          (empty),
    .data_o           (data),
    .valid_o          (valid),
    .ready_i          (ready),
    .level_o          (level)
  );

  function automatic logic [3:0] bin2gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] wp, input logic rdy);
    wptr_gray = wp;
    ready     = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    wptr_gray = '0;
    ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic collectBeats(input int max_cycles, input int want);
    got_q.delete();
    cyc_q.delete();
    for (int c = 0; c < max_cycles && got_q.size() < want; c++) begin
      if (valid && ready) begin
        got_q.push_back(data);
        cyc_q.push_back(c);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [3:0] wbin;
    logic [3:0] rbin_seen;
    logic [3:0] prev_rgray;
    int         wcount;
    int         cycles;

    // Cycle-by-cycle: one word (A5) arrives, then three more under backpressure.
    vecs[0]  = '{4'b0001, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 4'd0};
    vecs[1]  = '{4'b0001, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 4'd0};
    vecs[2]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 4'd1};
    vecs[3]  = '{4'b0001, 1'b0, 1'b1, 1'b1, 8'hA5, 4'b0001, 4'd0};
    vecs[4]  = '{4'b0110, 1'b0, 1'b1, 1'b1, 8'hA5, 4'b0001, 4'd0};
    vecs[5]  = '{4'b0110, 1'b0, 1'b1, 1'b1, 8'hA5, 4'b0001, 4'd0};
    vecs[6]  = '{4'b0110, 1'b0, 1'b0, 1'b1, 8'hA5, 4'b0001, 4'd3};
    vecs[7]  = '{4'b0110, 1'b0, 1'b0, 1'b1, 8'hA5, 4'b0001, 4'd3};
    vecs[8]  = '{4'b0110, 1'b1, 1'b0, 1'b1, 8'hB6, 4'b0011, 4'd2};
    vecs[9]  = '{4'b0110, 1'b1, 1'b0, 1'b1, 8'hC7, 4'b0010, 4'd1};
    vecs[10] = '{4'b0110, 1'b1, 1'b1, 1'b1, 8'hD8, 4'b0110, 4'd0};
    vecs[11] = '{4'b0110, 1'b1, 1'b1, 1'b0, 8'hD8, 4'b0110, 4'd0};
    vecs[12] = '{4'b0110, 1'b1, 1'b1, 1'b0, 8'hD8, 4'b0110, 4'd0};

    for (int i = 0; i < 8; i++) mem[i] = '0;

    // T1: reset values while reset is held
    rst_n     = 1'b0;
    wptr_gray = '0;
    ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t1_empty", empty, 1);
    checkOutput("t1_valid", valid, 0);
    checkOutput("t1_rgray", rgray, 0);
    checkOutput("t1_level", level, 0);
    checkOutput("t1_addr", read_addr, 0);
    rst_n = 1'b1;

    // T2/T4 cycle table
    mem[0] = 8'hA5;
    mem[1] = 8'hB6;
    mem[2] = 8'hC7;
    mem[3] = 8'hD8;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].wptr, vecs[i].rdy);
      checkOutput($sformatf("vec%0d_empty", i), empty, vecs[i].e_empty);
      checkOutput($sformatf("vec%0d_valid", i), valid, vecs[i].e_valid);
      checkOutput($sformatf("vec%0d_data", i), data, vecs[i].e_data);
      checkOutput($sformatf("vec%0d_rgray", i), rgray, vecs[i].e_rgray);
      checkOutput($sformatf("vec%0d_level", i), level, vecs[i].e_level);
    end

    // T3: full-depth burst with ready held high
    doReset();
    for (int i = 0; i < 8; i++) mem[i] = 8'(i);
    wptr_gray = 4'b1100;
    ready     = 1'b1;
    collectBeats(60, 8);
    checkOutput("t3_beat_count", got_q.size(), 8);
    for (int i = 0; i < got_q.size(); i++) begin
      checkOutput($sformatf("t3_beat%0d", i), got_q[i], i);
      checkOutput($sformatf("t3_b2b%0d", i), cyc_q[i], cyc_q[0] + i);
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t3_rgray", rgray, 4'b1100);
    checkOutput("t3_empty", empty, 1);
    checkOutput("t3_level", level, 0);
    checkOutput("t3_valid", valid, 0);

    // T4: backpressure holds one word in the output register
    doReset();
    mem[0] = 8'h11;
    mem[1] = 8'h22;
    mem[2] = 8'h33;
    wptr_gray = 4'b0010;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("t4_valid", valid, 1);
    checkOutput("t4_data", data, 8'h11);
    checkOutput("t4_level", level, 2);
    checkOutput("t4_rgray", rgray, 4'b0001);
    ready = 1'b1;
    collectBeats(30, 3);
    checkOutput("t4_beat_count", got_q.size(), 3);
    for (int i = 0; i < got_q.size(); i++) begin
      checkOutput($sformatf("t4_beat%0d", i), got_q[i], 8'h11 * (i + 1));
    end

    // T5: 40 words through a model writer, random consumer stalls, pointer wraps twice
    doReset();
    got_q.delete();
    wbin       = '0;
    wcount     = 0;
    cycles     = 0;
    prev_rgray = rgray;
    while (got_q.size() < 40 && cycles < 2000) begin
      if (valid && ready) got_q.push_back(data);
      if (rgray !== prev_rgray) begin
        checkOutput("t5_gray_onebit", $countones(rgray ^ prev_rgray), 1);
        prev_rgray = rgray;
      end
      rbin_seen = rgray;
      for (int b = AS - 1; b >= 0; b--) rbin_seen[b] = rbin_seen[b+1] ^ rgray[b];
      if (wcount < 40 && 4'(wbin - rbin_seen) < 4'd8) begin
        mem[wbin[2:0]] = 8'(8'h40 + wcount);
        wbin      = wbin + 4'd1;
        wcount++;
        wptr_gray = bin2gray(wbin);
      end
      ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("t5_beat_count", got_q.size(), 40);
    for (int i = 0; i < got_q.size(); i++) begin
      checkOutput($sformatf("t5_beat%0d", i), got_q[i], 8'h40 + i);
    end

    // T6: asynchronous reset while a word is pending and four remain in memory
    doReset();
    for (int i = 0; i < 5; i++) mem[i] = 8'(8'h90 + i);
    wptr_gray = 4'b0111;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("t6_pre_valid", valid, 1);
    checkOutput("t6_pre_level", level, 4);
    checkOutput("t6_pre_data", data, 8'h90);
    @(negedge clk);
    rst_n     = 1'b0;
    wptr_gray = '0;
    #1;
    checkOutput("t6_valid", valid, 0);
    checkOutput("t6_empty", empty, 1);
    checkOutput("t6_level", level, 0);
    checkOutput("t6_rgray", rgray, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
